// File: rtl/fixed_softermax_stream.sv
// Row-streaming base-2 softmax: buffers a row, tracks an online integer max and power-of-two sum, divides, then emits the normalised row.
// Latency: last input beat accepted at edge t -> W divider cycles -> first output beat valid from cycle t+W+1.
// Backpressure: input ready only while accumulating; output beat and read pointer hold while data_out_0_ready is low.
// Ports: clk/rst_n (async active-low); data_in_0[L] + valid/ready in; data_out_0[L] + valid/ready out.
module fixed_softermax_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 4,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 2,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 2,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 7,
  parameter int POW2_FRAC_WIDTH             = 8,
  parameter int RECIP_WIDTH                 = 16,
  parameter int MASK_MODE                   = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                                                data_in_0_valid,
  output logic                                                                data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0-1:0][DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                                                data_out_0_valid,
  input  logic                                                                data_out_0_ready
);
  localparam int IW   = DATA_IN_0_PRECISION_0;
  localparam int F    = DATA_IN_0_PRECISION_1;
  localparam int N    = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int ROWS = DATA_IN_0_TENSOR_SIZE_DIM_1;
  localparam int L    = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int OW   = DATA_OUT_0_PRECISION_0;
  localparam int O    = DATA_OUT_0_PRECISION_1;
  localparam int P    = POW2_FRAC_WIDTH;
  localparam int W    = RECIP_WIDTH;
  localparam int NB   = N / L;
  localparam int PW   = P + 1;
  localparam int SW   = P + 1 + $clog2(N);
  localparam int MW   = IW - F;          // integer part of x, signed
  localparam int EW   = IW + 2;          // x - M never overflows this
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (W > 1) ? $clog2(W) : 1;
  localparam int CLW  = $clog2(N) + 1;

  // Elaboration-time 2^(f/2^F) in 30-bit fixed point, built from repeated
  // square roots of 2. Truncation keeps every entry at or below the true
  // value; f=0 is exact, so floor() is preserved for P up to 30.
  function automatic longint unsigned isqrt64(input longint unsigned v);
    longint unsigned res, t;
    res = 0;
    for (int b = 31; b >= 0; b--) begin
      t = res | (64'd1 << b);
      if (t * t <= v) res = t;
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] lut_entry(input int f);
    longint unsigned acc, root;
    acc  = 64'd1 << 30;
    root = 64'd2 << 30;
    for (int k = 1; k <= F; k++) begin
      root = isqrt64(root << 30);
      if (f[F-k]) acc = (acc * root) >> 30;
    end
    return PW'(acc >> (30 - P));
  endfunction

  typedef enum logic [1:0] {ACCUM, DIVIDE, EMIT} state_t;

  state_t                    r_state;
  logic [BW-1:0]             r_wptr, r_rptr;
  logic signed [MW-1:0]      r_m;
  logic [SW-1:0]             r_s;
  logic [SW-1:0]             r_rem;
  logic [W-1:0]              r_q;
  logic [CW-1:0]             r_cnt;
  logic [RW-1:0]             r_row;
  logic [L-1:0][IW-1:0]      r_buf [NB];

  logic [PW-1:0]             w_lut [2**F];
  logic [BW-1:0]             w_ptr;
  logic [L-1:0]              w_live;
  logic                      w_any;
  logic signed [MW-1:0]      w_mb, w_m_new, w_pm;
  logic [MW:0]               w_d;
  logic [PW-1:0]             w_p [L];
  logic [SW-1:0]             w_psum, w_s_new;
  logic [SW:0]               w_trial;
  logic                      w_in_hs, w_out_hs;

  for (genvar g = 0; g < 2**F; g++) begin : g_lut
    localparam logic [PW-1:0] LV = lut_entry(g);
    assign w_lut[g] = LV;
  end

  assign data_in_0_ready  = (r_state == ACCUM);
  assign data_out_0_valid = (r_state == EMIT);
  assign w_in_hs  = data_in_0_valid && data_in_0_ready;
  assign w_out_hs = data_out_0_valid && data_out_0_ready;

  // Lane liveness for the beat currently being accepted or emitted.
  always_comb begin
    logic [CLW-1:0] col;
    w_ptr  = (r_state == EMIT) ? r_rptr : r_wptr;
    w_live = '0;
    for (int j = 0; j < L; j++) begin
      col = CLW'(w_ptr) * CLW'(L) + CLW'(j);
      w_live[j] = (MASK_MODE == 0) || (col <= CLW'(r_row));
    end
  end

  // Integer max over live lanes; a beat may be fully masked (w_any=0).
  always_comb begin
    w_any = 1'b0;
    w_mb  = '0;
    for (int j = 0; j < L; j++) begin
      if (w_live[j] && (!w_any || $signed(data_in_0[j][IW-1:F]) > w_mb)) begin
        w_mb  = data_in_0[j][IW-1:F];
        w_any = 1'b1;
      end
    end
  end

  // Beat 0 always contains live column 0, so it seeds M unconditionally.
  assign w_m_new = (r_wptr == '0 || (w_any && w_mb > r_m)) ? w_mb : r_m;
  assign w_d     = {w_m_new[MW-1], w_m_new} - {r_m[MW-1], r_m};
  // The pow2 lanes are shared: input beat with the new max while
  // accumulating, buffered beat with the final max while emitting.
  assign w_pm    = (r_state == EMIT) ? r_m : w_m_new;

  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [IW-1:0]        w_x;
    logic signed [EW-1:0] w_e;
    logic [EW-1:0]        w_nk;
    logic [PW+W-1:0]      w_prod, w_sh;
    assign w_x    = (r_state == EMIT) ? r_buf[r_rptr][j] : data_in_0[j];
    assign w_e    = $signed({{(EW-IW){w_x[IW-1]}}, w_x})
                  - $signed({{(EW-MW-F){w_pm[MW-1]}}, w_pm, {F{1'b0}}});
    assign w_nk   = -(w_e >>> F);
    assign w_p[j] = w_live[j] ? (w_lut[w_e[F-1:0]] >> w_nk) : '0;
    assign w_prod = w_p[j] * r_q;
    assign w_sh   = w_prod >> (W - O);
    assign data_out_0[j] = (r_state != EMIT) ? '0 :
                           (|w_sh[PW+W-1:OW]) ? {OW{1'b1}} : w_sh[OW-1:0];
  end

  always_comb begin
    w_psum = '0;
    for (int j = 0; j < L; j++) w_psum = w_psum + SW'(w_p[j]);
  end

  assign w_s_new = ((r_wptr == '0) ? '0 : (r_s >> w_d)) + w_psum;
  assign w_trial = {r_rem, 1'b0};

  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_wptr] <= data_in_0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_m     <= '0;
      r_s     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        ACCUM: if (w_in_hs) begin
          r_m <= w_m_new;
          r_s <= w_s_new;
          if (r_wptr == BW'(NB - 1)) begin
            r_wptr  <= '0;
            // Quotient bit W of 2^W/S is always 0 since S >= 2^P, so the
            // remainder starts at 1 and W steps shift in the zero bits.
            r_rem   <= SW'(1);
            r_q     <= '0;
            r_cnt   <= '0;
            r_state <= DIVIDE;
          end else begin
            r_wptr <= r_wptr + 1'b1;
          end
        end
        DIVIDE: begin
          if (w_trial >= {1'b0, r_s}) begin
            r_rem <= SW'(w_trial - {1'b0, r_s});
            r_q   <= {r_q[W-2:0], 1'b1};
          end else begin
            r_rem <= SW'(w_trial);
            r_q   <= {r_q[W-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= EMIT;
        end
        EMIT: if (w_out_hs) begin
          if (r_rptr == BW'(NB - 1)) begin
            r_rptr  <= '0;
            r_state <= ACCUM;
            r_row   <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
          end else begin
            r_rptr <= r_rptr + 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_softermax_stream.sv
module tb_fixed_softermax_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0][7:0] in0, in1, out0, out1;
  logic            in0_vld, in1_vld, in0_rdy, in1_rdy;
  logic            out0_vld, out1_vld, out0_rdy, out1_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  int q0[$];
  int q1[$];
  logic [1:0][7:0] prev0;
  logic            stall0 = 1'b0;
  logic            feed_done;

  fixed_softermax_stream #(.MASK_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(in0), .data_in_0_valid(in0_vld), .data_in_0_ready(in0_rdy),
    .data_out_0(out0), .data_out_0_valid(out0_vld), .data_out_0_ready(out0_rdy)
  );

  fixed_softermax_stream #(.MASK_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_in_0(in1), .data_in_0_valid(in1_vld), .data_in_0_ready(in1_rdy),
    .data_out_0(out1), .data_out_0_valid(out1_vld), .data_out_0_ready(out1_rdy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: a handshake happens at the posedge following a
  // negedge where valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && out0_vld) begin
      check("dut0_in_rdy_low_in_emit", int'(in0_rdy), 0);
      if (stall0) begin
        check("dut0_stall_stable_l0", int'(out0[0]), int'(prev0[0]));
        check("dut0_stall_stable_l1", int'(out0[1]), int'(prev0[1]));
      end
      if (out0_rdy) begin
        for (int j = 0; j < 2; j++) begin
          if (q0.size() == 0) check("dut0_unexpected_output", int'(out0[j]), -1);
          else check($sformatf("dut0_out_lane%0d", j), int'(out0[j]), q0.pop_front());
        end
      end
      stall0 = !out0_rdy;
      prev0  = out0;
    end else begin
      stall0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out1_vld) begin
      check("dut1_in_rdy_low_in_emit", int'(in1_rdy), 0);
      if (out1_rdy) begin
        for (int j = 0; j < 2; j++) begin
          if (q1.size() == 0) check("dut1_unexpected_output", int'(out1[j]), -1);
          else check($sformatf("dut1_out_lane%0d", j), int'(out1[j]), q1.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic put(input int dut, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    if (dut == 0) begin in0 = {b, a}; in0_vld = 1'b1; end
    else          begin in1 = {b, a}; in1_vld = 1'b1; end
    @(negedge clk);
    while (((dut == 0) ? !in0_rdy : !in1_rdy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("input_accept_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  // Called just after the last accepting edge: DIVIDE keeps valid low for W samples.
  task automatic measure_latency0();
    int n = 0;
    @(negedge clk);
    while (!out0_vld && n < 100) begin
      check("dut0_in_rdy_low_in_divide", int'(in0_rdy), 0);
      n++;
      @(negedge clk);
    end
    check("dut0_first_output_latency", n, 16);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", q0.size() + q1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push4(input int dut, input int a, input int b, input int c, input int d);
    if (dut == 0) begin q0.push_back(a); q0.push_back(b); q0.push_back(c); q0.push_back(d); end
    else          begin q1.push_back(a); q1.push_back(b); q1.push_back(c); q1.push_back(d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in0 = '0; in1 = '0; in0_vld = 1'b0; in1_vld = 1'b0;
    out0_rdy = 1'b1; out1_rdy = 1'b1; feed_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_dut0_in_rdy",  int'(in0_rdy), 1);
    check("reset_dut0_out_vld", int'(out0_vld), 0);
    check("reset_dut0_out",     int'(out0), 0);
    check("reset_dut1_in_rdy",  int'(in1_rdy), 1);
    check("reset_dut1_out_vld", int'(out1_vld), 0);
    check("reset_dut1_out",     int'(out1), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero row: S=1024, R=64.
    push4(0, 32, 32, 32, 32);
    put(0, 8'h00, 8'h00);
    put(0, 8'h00, 8'h00);
    in0_vld = 1'b0;
    measure_latency0();
    wait_drain();

    // [4.0, 0, 0, 0]: M=4, S=304, R=215.
    push4(0, 107, 6, 6, 6);
    put(0, 8'd64, 8'h00);
    put(0, 8'h00, 8'h00);
    in0_vld = 1'b0;
    wait_drain();

    // Online max shift: [-2, -2 | 1.5, 1.5] -> S=788, R=83.
    push4(0, 5, 5, 58, 58);
    put(0, 8'hE0, 8'hE0);
    put(0, 8'd24, 8'd24);
    in0_vld = 1'b0;
    wait_drain();

    // Causal mask, three zero rows with the row index wrapping after two.
    push4(1, 128, 0, 0, 0);
    push4(1, 64, 64, 0, 0);
    push4(1, 128, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      put(1, 8'h00, 8'h00);
      put(1, 8'h00, 8'h00);
    end
    in1_vld = 1'b0;
    wait_drain();

    // Backpressure: random output ready, input valid held across two rows.
    push4(0, 107, 6, 6, 6);
    push4(0, 5, 5, 58, 58);
    feed_done = 1'b0;
    fork
      begin
        put(0, 8'd64, 8'h00);
        put(0, 8'h00, 8'h00);
        measure_latency0();
        put(0, 8'hE0, 8'hE0);
        put(0, 8'd24, 8'd24);
        in0_vld = 1'b0;
        feed_done = 1'b1;
      end
      begin
        for (int c = 0; c < 1500 && !(feed_done && q0.size() == 0); c++) begin
          out0_rdy = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        check("bp_feed_done", int'(feed_done), 1);
        check("bp_outputs_consumed", q0.size(), 0);
      end
    join
    out0_rdy = 1'b1;
    wait_drain();

    // Reset during DIVIDE discards the row; next zero row is clean.
    put(0, 8'd64, 8'h00);
    put(0, 8'h00, 8'h00);
    in0_vld = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_in_divide", int'(in0_rdy), 0);
    rst_n = 1'b0;
    #1;
    check("async_reset_in_rdy",  int'(in0_rdy), 1);
    check("async_reset_out_vld", int'(out0_vld), 0);
    check("async_reset_out",     int'(out0), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push4(0, 32, 32, 32, 32);
    put(0, 8'h00, 8'h00);
    put(0, 8'h00, 8'h00);
    in0_vld = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
